// File: rtl/i2c_pkg.sv
// ============================================================================
// Package     : i2c_pkg
// Description : Shared types and constants for the I2C responder block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_CNT_W  = 4;

  localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'h3C;

  // Protocol states of the responder; TX is only reachable in read-enabled builds
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5,
    ST_TX       = 3'd6
  } state_t;

  // True when the received 7-bit address selects this target
  function automatic logic addr_hit(input logic [I2C_ADDR_W-1:0] got,
                                    input logic [I2C_ADDR_W-1:0] own);
    return (got == own);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// Module      : i2c_line_sync
// Description : Two-flop synchronizers for SCL/SDA, a history flop per line
//               for edge strobes, and START/STOP condition detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  logic scl_meta, scl_sync, scl_hist;
  logic sda_meta, sda_sync, sda_hist;

  // Synchronizer and history flops; reset to the idle (released) bus level
  // so that leaving reset never fabricates an edge on a quiet bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  assign scl_rise = scl_sync & ~scl_hist;
  assign scl_fall = ~scl_sync & scl_hist;
  assign sda_s    = sda_sync;

  // SDA may only move while SCL is high to signal a bus condition
  assign start = scl_sync & sda_hist & ~sda_sync;
  assign stop  = scl_sync & ~sda_hist & sda_sync;

endmodule

`default_nettype wire

// File: rtl/i2c_responder.sv
// ============================================================================
// Module      : i2c_responder
// Description : I2C target that ACKs its address, receives write bytes into
//               data_out and drives the LED from bit 0 of the last byte.
//               Optional macro I2C_RESPONDER_READ_EN adds a read (TX) path
//               that returns data_out MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = I2C_DEFAULT_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] data_out,
  output logic                  data_valid,
  output logic                  led,
  output logic                  busy
);

  logic scl_rise, scl_fall, sda_s, start, stop;

  state_t                state, state_n;
  logic [I2C_CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [I2C_BYTE_W-1:0] shreg, shreg_n;
  logic [I2C_BYTE_W-1:0] data_out_n;
  logic                  sda_oe_n, data_valid_n, busy_n;
  logic                  byte_done, own_addr;
`ifdef I2C_RESPONDER_READ_EN
  logic                  rw_q, rw_n;
`endif

  i2c_line_sync u_line_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start    (start),
    .stop     (stop)
  );

  // The 8th rise of a byte: counter still reads 7 before it advances
  assign byte_done = scl_rise && (bit_cnt == 4'd7);
  // Address bits [7:1] are already in the shifter when the R/W bit arrives
  assign own_addr  = addr_hit(shreg[I2C_BYTE_W-2:0], ADDR);

  // State and datapath registers; async reset releases SDA immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_oe     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
`ifdef I2C_RESPONDER_READ_EN
      rw_q       <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      sda_oe     <= sda_oe_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      busy       <= busy_n;
`ifdef I2C_RESPONDER_READ_EN
      rw_q       <= rw_n;
`endif
    end
  end

  // Next-state and output decode; STOP outranks START, which outranks bit activity
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    sda_oe_n     = sda_oe;
    data_out_n   = data_out;
    data_valid_n = 1'b0;
    busy_n       = busy;
`ifdef I2C_RESPONDER_READ_EN
    rw_n         = rw_q;
`endif

    if (stop) begin
      state_n   = ST_IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (start) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[I2C_BYTE_W-2:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (byte_done) begin
`ifdef I2C_RESPONDER_READ_EN
              rw_n = sda_s;
              if (own_addr) begin
                state_n = ST_ADDR_ACK;
                busy_n  = 1'b1;
              end else begin
                state_n = ST_IGNORE;
                busy_n  = 1'b0;
              end
`else
              if (own_addr && !sda_s) begin
                state_n = ST_ADDR_ACK;
                busy_n  = 1'b1;
              end else begin
                state_n = ST_IGNORE;
                busy_n  = 1'b0;
              end
`endif
            end
          end
        end

        // First fall after bit 8 pulls SDA; the next fall ends the ACK clock
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_DATA;
`ifdef I2C_RESPONDER_READ_EN
              if (state == ST_ADDR_ACK && rw_q) begin
                state_n  = ST_TX;
                shreg_n  = data_out;
                sda_oe_n = ~data_out[I2C_BYTE_W-1];
              end
`endif
            end
          end
        end

        ST_DATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[I2C_BYTE_W-2:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (byte_done) begin
              data_out_n   = {shreg[I2C_BYTE_W-2:0], sda_s};
              data_valid_n = 1'b1;
              state_n      = ST_DATA_ACK;
            end
          end
        end

`ifdef I2C_RESPONDER_READ_EN
        // Bit k is presented on the fall that follows rise k; the 9th rise
        // samples the initiator's ACK
        ST_TX: begin
          if (scl_rise) begin
            if (bit_cnt == 4'd8) begin
              if (!sda_s) begin
                bit_cnt_n = '0;
                shreg_n   = data_out;
              end else begin
                state_n = ST_IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end else if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              sda_oe_n = ~shreg[I2C_BYTE_W-1];
            end else if (bit_cnt < 4'd8) begin
              shreg_n  = {shreg[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_n = ~shreg[I2C_BYTE_W-2];
            end else begin
              sda_oe_n = 1'b0;
            end
          end
        end
`endif

        default: ;
      endcase
    end
  end

  assign led = data_out[0];

endmodule

`default_nettype wire

// File: tb/tb_i2c_responder.sv
// ============================================================================
// Module      : tb_i2c_responder
// Description : Self-checking bench for i2c_responder (open-drain bus model,
//               table of write transactions plus hand-written corner cases).
//               Read-path checks compile when I2C_RESPONDER_READ_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_responder;

  localparam int Q = 5;  // quarter SCL period in clk cycles (SCL = clk/20)

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_drv;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data_out;
  logic       data_valid;
  logic       led;
  logic       busy;

  // Open-drain bus: low if either side pulls
  assign sda_in = sda_drv & ~sda_oe;

  i2c_responder #(.ADDR(7'h3C)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .led        (led),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   oe_cycles   = 0;
  int   dv_cycles   = 0;
  int   dv_pulses   = 0;
  logic dv_prev     = 1'b0;

  // Activity monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_cycles++;
    if (data_valid === 1'b1) dv_cycles++;
    if (data_valid === 1'b1 && dv_prev !== 1'b1) dv_pulses++;
    dv_prev = data_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; scl = 1'b1; sda_drv = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; cyc(Q);
    scl = 1'b1;     cyc(Q);
    sda_drv = 1'b0; cyc(Q);
    scl = 1'b0;     cyc(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; cyc(Q);
    scl = 1'b1;     cyc(Q);
    sda_drv = 1'b1; cyc(2*Q);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; cyc(Q);
    scl = 1'b1;  cyc(2*Q);
    scl = 1'b0;  cyc(Q);
  endtask

  task automatic ack_slot(output logic acked);
    sda_drv = 1'b1; cyc(Q);
    scl = 1'b1;     cyc(Q);
    acked = sda_oe;
    cyc(Q);
    scl = 1'b0;     cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_slot(acked);
  endtask

  typedef struct {
    logic [7:0]      addr;
    int              nbytes;
    logic [2:0][7:0] d;
    logic            exp_ack;
    logic [7:0]      exp_dout;
    int              exp_dv;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic       a;
    int         acks, o0, c0, p0;
    logic [7:0] pat;

    // addr byte, nbytes, data (d[0] is the first byte), ack, data_out, pulses
    tbl[0] = '{8'h78, 1, {8'h00, 8'h00, 8'hA5}, 1'b1, 8'hA5, 1};
    tbl[1] = '{8'h7A, 1, {8'h00, 8'h00, 8'hFF}, 1'b0, 8'h00, 0};
    tbl[2] = '{8'h78, 3, {8'h03, 8'h02, 8'h01}, 1'b1, 8'h03, 3};
    tbl[3] = '{8'h78, 1, {8'h00, 8'h00, 8'h00}, 1'b1, 8'h00, 1};
    tbl[4] = '{8'h00, 2, {8'h00, 8'hAA, 8'h55}, 1'b0, 8'h00, 0};
    tbl[5] = '{8'h78, 2, {8'h00, 8'hFE, 8'h80}, 1'b1, 8'hFE, 2};

    do_reset();
    check("rst_sda_oe", sda_oe, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);

    // Table-driven write transactions, each from a fresh reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      o0 = oe_cycles; c0 = dv_cycles; p0 = dv_pulses;
      bus_start();
      send_byte(tbl[v].addr, a);
      check($sformatf("v%0d_addr_ack", v), a, tbl[v].exp_ack);
      check($sformatf("v%0d_busy_mid", v), busy, tbl[v].exp_ack);
      acks = 0;
      for (int b = 0; b < tbl[v].nbytes; b++) begin
        send_byte(tbl[v].d[b], a);
        if (a) acks++;
      end
      check($sformatf("v%0d_data_acks", v), acks, tbl[v].exp_ack ? tbl[v].nbytes : 0);
      bus_stop();
      check($sformatf("v%0d_data_out", v), data_out, tbl[v].exp_dout);
      check($sformatf("v%0d_led", v), led, tbl[v].exp_dout[0]);
      check($sformatf("v%0d_dv_pulses", v), dv_pulses - p0, tbl[v].exp_dv);
      check($sformatf("v%0d_dv_cycles", v), dv_cycles - c0, tbl[v].exp_dv);
      check($sformatf("v%0d_busy_end", v), busy, 0);
      check($sformatf("v%0d_oe_end", v), sda_oe, 0);
      check($sformatf("v%0d_oe_seen", v), (oe_cycles - o0) != 0, tbl[v].exp_ack);
    end

    // Reset asserted while the address ACK is being driven
    do_reset();
    bus_start();
    pat = 8'h78;
    for (int i = 7; i >= 0; i--) send_bit(pat[i]);
    sda_drv = 1'b1;
    for (int k = 0; k < 20 && sda_oe !== 1'b1; k++) cyc(1);
    check("midack_oe_before_reset", sda_oe, 1);
    check("midack_busy_before_reset", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midack_oe_async", sda_oe, 0);
    check("midack_busy_async", busy, 0);
    check("midack_dout_async", data_out, 8'h00);
    check("midack_dv_async", data_valid, 0);
    check("midack_led_async", led, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    o0 = oe_cycles;
    send_byte(8'h78, a);
    check("no_ack_without_start", a, 0);
    check("no_oe_without_start", oe_cycles - o0, 0);
    bus_stop();
    bus_start();
    send_byte(8'h78, a);
    check("resume_addr_ack", a, 1);
    send_byte(8'h3C, a);
    bus_stop();
    check("resume_data_out", data_out, 8'h3C);
    check("resume_led", led, 0);

    // Repeated START drops a partial byte
    do_reset();
    p0 = dv_pulses;
    bus_start();
    send_byte(8'h78, a);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus_start();
    send_byte(8'h78, a);
    check("rstart_addr_ack", a, 1);
    send_byte(8'h0E, a);
    bus_stop();
    check("rstart_data_out", data_out, 8'h0E);
    check("rstart_led", led, 0);
    check("rstart_dv_pulses", dv_pulses - p0, 1);
    check("rstart_busy", busy, 0);

    // STOP in the middle of a byte discards it
    do_reset();
    p0 = dv_pulses;
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'hA5, a);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    check("pstop_data_out", data_out, 8'hA5);
    check("pstop_dv_pulses", dv_pulses - p0, 1);
    check("pstop_oe", sda_oe, 0);
    check("pstop_busy", busy, 0);

`ifdef I2C_RESPONDER_READ_EN
    // Read back a previously written byte, then NACK
    do_reset();
    bus_start();
    send_byte(8'h78, a);
    send_byte(8'h5A, a);
    bus_stop();
    bus_start();
    send_byte(8'h79, a);
    check("rd_addr_ack", a, 1);
    check("rd_busy", busy, 1);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; cyc(Q);
      scl = 1'b1;     cyc(Q);
      pat[i] = sda_in;
      cyc(Q);
      scl = 1'b0;     cyc(Q);
    end
    check("rd_byte", pat, 8'h5A);
    sda_drv = 1'b1; cyc(Q);
    scl = 1'b1;     cyc(2*Q);
    scl = 1'b0;     cyc(Q);
    check("rd_release_after_nack", sda_oe, 0);
    bus_stop();
    check("rd_busy_end", busy, 0);
`else
    // Read request is not acknowledged when reads are not built in
    do_reset();
    o0 = oe_cycles;
    bus_start();
    send_byte(8'h79, a);
    check("rd_addr_nack", a, 0);
    check("rd_busy", busy, 0);
    bus_stop();
    check("rd_no_oe", oe_cycles - o0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_responder.md
# i2c_responder

I2C target (responder) that receives writes from the `InvertedPend` I2C initiator and latches each data byte for the board. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it, shifts in data bytes and drives the LED from the last byte. SDA is open-drain: the block only ever pulls low.

## Interface
- `ADDR`, 7'h3C, 7-bit target address matched on the first byte after START.
- `clk`  in  1  system clock; must be ≥ 8× the SCL frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `scl`  in  1  bus clock from the initiator; asynchronous to `clk`.
- `sda_in`  in  1  bus data as sensed at the pad.
- `sda_oe`  out  1  1 = pull SDA low, 0 = release (the tristate sits outside this block).
- `data_out`  out  8  last received data byte.
- `data_valid`  out  1  one-`clk` pulse when a new byte lands in `data_out`.
- `led`  out  1  `data_out[0]`.
- `busy`  out  1  high from an address match until STOP or a non-matching START.

## Operation
- Line conditioning:
  - `scl` and `sda_in` each pass through a 2-flop synchronizer, then a history flop gives rise/fall strobes.
  - START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while SCL is high.
- FSM states and transitions:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits, sampled MSB first on SCL rising edges. Bits [7:1] are the address; bit 0 is R/W.
  - ADDR → ADDR_ACK if the address matches and R/W=0. Otherwise → IGNORE.
  - ADDR_ACK: assert `sda_oe` on the SCL fall after bit 8 and hold it through the 9th clock. Release it on the following SCL fall, then → DATA.
  - DATA: shift 8 bits. On the 8th rise, `data_out` loads the byte and `data_valid` pulses. Then → DATA_ACK.
  - DATA_ACK: same pull-low timing as ADDR_ACK, then → DATA. There is no limit on the number of bytes.
  - IGNORE: `sda_oe` stays 0 until STOP or START.
- Boundary conditions:
  - STOP in any state → IDLE. `sda_oe` drops the same cycle; a partial byte is discarded.
  - START in any state (repeated start) → ADDR, with the bit counter cleared.
  - A mismatched address is never ACKed.
  - Asynchronous reset mid-transfer releases `sda_oe` immediately; the FSM resumes only on the next START.
- Bit counter: 4 bits, counts 0–8, cleared on entry to ADDR/DATA.

## Timing
- Reset values: `sda_oe`=0, `data_out`=8'h00, `data_valid`=0, `led`=0, `busy`=0. FSM resets to IDLE.
- Latency from a pad edge to a detected event is 3 `clk` cycles (2 sync + 1 edge).
- `sda_oe` changes 1 cycle after the detected SCL fall. SDA is therefore stable well before the next SCL rise at ≥ 8× oversampling.
- `data_valid` is high exactly one cycle, 1 cycle after the detected 8th SCL rise. `data_out` and `led` update on that same cycle.
- `busy` rises 1 cycle after the 8th address bit matches. It falls 1 cycle after STOP is detected.

## Configuration
- `I2C_RESPONDER_READ_EN` defined:
  - R/W=1 with a matching address is ACKed and the FSM enters TX.
  - TX shifts out `data_out` MSB first, changing `sda_oe` (=~bit) on each SCL fall.
  - On the 9th rise, the initiator's ACK (SDA low) reloads the byte and TX continues. NACK → IGNORE.
- Undefined: R/W=1 → IGNORE (no ACK), and no TX state exists.

## Structure
- Package `i2c_pkg`:
  - state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE, TX)
  - `I2C_ADDR_W`=7, `I2C_BYTE_W`=8
  - default address constant 7'h3C
- Sub-module `i2c_line_sync` holds the synchronizers, edge strobes and START/STOP detect. Its outputs are `scl_rise`, `scl_fall`, `sda_s`, `start`, `stop`.

## Test plan
- Reset asserted mid-ACK (`sda_oe`=1) → `sda_oe`=0 the same cycle. All outputs return to their reset values.
- START, 0x78 (0x3C, write), 0xA5, STOP → ACK on both 9th clocks, `data_out`=8'hA5, one `data_valid` pulse, `led`=1, `busy` falls after STOP.
- START, 0x7A (0x3D, write), 0xFF → no ACK (`sda_oe` never 1), `data_valid` never pulses, `data_out` stays 8'h00.
- START, 0x78, 0x01, 0x02, 0x03, STOP → three `data_valid` pulses, final `data_out`=8'h03, `led`=1.
- START, 0x78, 4 bits of 0xF0, repeated START, 0x78, 0x0E, STOP → the partial byte is dropped, `data_out`=8'h0E, `led`=0.
- With `I2C_RESPONDER_READ_EN`: after a write of 0x5A, START, 0x79, initiator NACK → SDA reads 0x5A MSB first, then the block releases SDA.
